// File: rtl/uart_pkg.sv
// Shared UART definitions: launcher FSM encoding, default data width and
// the oversampling constant used by the receive/transmit bit engines.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_t;

    localparam int DBIT_DEFAULT = 8;
    localparam int SB_TICK      = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the transmit FIFO: synchronous write, combinational read.
// Holds no pointers or flags; those live in the owning buffer.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DBIT-1:0]   i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DBIT-1:0]   o_rdata
);

    logic [DBIT-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO plus launcher: buffers host bytes and hands them one at a time
// to the UART transmitter, waiting for its done tick between bytes.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEFAULT,
    parameter int ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [DBIT-1:0]   i_wdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    input  logic              i_tx_done_tick,
    output logic              o_busy
);

    localparam int              DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    tx_state_t         r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_tx_start;
    logic [DBIT-1:0]   r_tx_data;
    logic              r_busy;

    logic              w_push;
    logic              w_pop;
    logic [DBIT-1:0]   w_rdata;

    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_level    = r_count;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign w_push     = i_wr && !o_full;
    assign o_overflow = i_wr && o_full;
    assign w_pop      = (r_state == IDLE) && !o_empty;

    uart_fifo_mem #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clock (i_clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx_start <= 1'b0;
                    if (w_pop) begin
                        r_tx_data  <= w_rdata;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    r_tx_start <= 1'b0;
                    if (i_tx_done_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: queue-based reference model plus a
// scoreboard monitor that checks every launched byte in order.
module tb_uart_tx_buffer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr;
    logic [7:0] wdata;
    logic       done;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       txStart;
    logic [7:0] txData;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] sbQueue[$];
    logic [7:0] refFifo[$];
    bit         refBusy;
    bit         refStart;
    logic [7:0] refData;

    always #5 clock = ~clock;

    uart_tx_buffer #(
        .DBIT   (8),
        .ADDR_W (4)
    ) dut (
        .i_clock        (clock),
        .i_reset_n      (reset_n),
        .i_wr           (wr),
        .i_wdata        (wdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_level        (level),
        .o_overflow     (overflow),
        .o_tx_start     (txStart),
        .o_tx_data      (txData),
        .i_tx_done_tick (done),
        .o_busy         (busy)
    );

    task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every start pulse must carry the oldest accepted byte.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && txStart === 1'b1) begin
            if (sbQueue.size() == 0) begin
                compareVal("unexpected_start", {31'd0, txStart}, 32'd0);
            end else begin
                logic [7:0] expByte;
                expByte = sbQueue.pop_front();
                compareVal("tx_byte", {24'd0, txData}, {24'd0, expByte});
            end
        end
    end

    task automatic checkOutput(input bit w);
        int sz;
        sz = refFifo.size();
        compareVal("start",    {31'd0, txStart},  {31'd0, refStart});
        compareVal("busy",     {31'd0, busy},     {31'd0, refBusy});
        compareVal("level",    {27'd0, level},    sz);
        compareVal("empty",    {31'd0, empty},    {31'd0, sz == 0});
        compareVal("full",     {31'd0, full},     {31'd0, sz == 16});
        compareVal("overflow", {31'd0, overflow}, {31'd0, w && sz == 16});
        compareVal("tx_data",  {24'd0, txData},   {24'd0, refData});
    endtask

    // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit dn);
        int  preSize;
        bit  accepted;
        @(negedge clock);
        wr    = w;
        wdata = d;
        done  = dn;
        #1;
        checkOutput(w);
        @(posedge clock);
        preSize  = refFifo.size();
        accepted = w && (preSize < 16);
        refStart = 1'b0;
        if (!refBusy && preSize > 0) begin
            refData  = refFifo.pop_front();
            refBusy  = 1'b1;
            refStart = 1'b1;
        end else if (refBusy && dn) begin
            refBusy = 1'b0;
        end
        if (accepted) begin
            refFifo.push_back(d);
            sbQueue.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drainAll();
        for (int i = 0; i < 40 && (refBusy || refFifo.size() > 0); i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            idle(1);
        end
        compareVal("drained_empty", {31'd0, empty}, 32'd1);
    endtask

    task automatic doAsyncReset();
        #3;
        wr      = 1'b0;
        done    = 1'b0;
        reset_n = 1'b0;
        #1;
        compareVal("rst_start",    {31'd0, txStart},  32'd0);
        compareVal("rst_data",     {24'd0, txData},   32'd0);
        compareVal("rst_busy",     {31'd0, busy},     32'd0);
        compareVal("rst_empty",    {31'd0, empty},    32'd1);
        compareVal("rst_full",     {31'd0, full},     32'd0);
        compareVal("rst_level",    {27'd0, level},    32'd0);
        compareVal("rst_overflow", {31'd0, overflow}, 32'd0);
        refFifo.delete();
        sbQueue.delete();
        refBusy  = 1'b0;
        refStart = 1'b0;
        refData  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset_n  = 1'b1;
        wr       = 1'b0;
        wdata    = 8'h00;
        done     = 1'b0;
        refBusy  = 1'b0;
        refStart = 1'b0;
        refData  = 8'h00;

        @(posedge clock);
        doAsyncReset();

        $display("[TB] single byte latency");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        #2;
        compareVal("first_empty_fall", {31'd0, empty},   32'd0);
        compareVal("first_no_start",   {31'd0, txStart}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        compareVal("first_start",      {31'd0, txStart}, 32'd1);
        compareVal("first_data",       {24'd0, txData},  32'hA5);
        compareVal("first_busy",       {31'd0, busy},    32'd1);
        idle(1);
        #2;
        compareVal("first_start_width", {31'd0, txStart}, 32'd0);
        idle(5);
        applyStimulus(1'b0, 8'h00, 1'b1);
        #2;
        compareVal("first_busy_clear", {31'd0, busy}, 32'd0);

        $display("[TB] spurious done in idle");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        idle(2);
        #2;
        compareVal("spurious_busy",  {31'd0, busy},    32'd0);
        compareVal("spurious_start", {31'd0, txStart}, 32'd0);

        $display("[TB] burst to full and overflow");
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        #2;
        compareVal("burst_level", {27'd0, level}, 32'd16);
        compareVal("burst_full",  {31'd0, full},  32'd1);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        #2;
        compareVal("burst_overflow",    {31'd0, overflow}, 32'd1);
        compareVal("burst_level_after", {27'd0, level},    32'd16);
        drainAll();

        $display("[TB] slow done ticks");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, vals[i], 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(198);
            applyStimulus(1'b0, 8'h00, 1'b1);
            applyStimulus(1'b0, 8'h00, 1'b0);
            #2;
            if (k < 3) begin
                compareVal("gap_start", {31'd0, txStart}, 32'd1);
                compareVal("gap_data",  {24'd0, txData},  {24'd0, vals[k+1]});
            end else begin
                compareVal("gap_no_start", {31'd0, txStart}, 32'd0);
            end
            if (k >= 2) compareVal("gap_empty", {31'd0, empty}, 32'd1);
        end

        $display("[TB] push and pop together with pointer wrap");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 36; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            applyStimulus(1'b1, 8'($urandom), 1'b0);
            #2;
            compareVal("simul_level", {27'd0, level}, 32'd3);
            idle($urandom_range(2));
        end
        drainAll();

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(1) == 1), 8'($urandom), ($urandom_range(7) == 0));
        end
        drainAll();

        $display("[TB] reset during transfer");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        idle(2);
        #2;
        compareVal("pre_reset_level", {27'd0, level}, 32'd5);
        compareVal("pre_reset_busy",  {31'd0, busy},  32'd1);
        doAsyncReset();
        idle(10);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        compareVal("post_reset_start", {31'd0, txStart}, 32'd1);
        compareVal("post_reset_data",  {24'd0, txData},  32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);
        compareVal("sb_leftover", sbQueue.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
